// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow flag is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [WIDTH-1:0] diff_q;
  logic             br, borrow_q, done_q;
  logic [CW-1:0]    cnt;
  logic             d, br_nx, last;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_nx    = (~a_sh[0] & b_sh[0]) | (b_sh[0] & br) | (br & ~a_sh[0]);
    last     = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result registers move only on the final bit step, so partial sums never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            br   <= bus.bin;
            res  <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff_q   <= {d, res[WIDTH-1:1]};
            borrow_q <= br_nx;
            done_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into vs. out of the sign bit flags two's-complement overflow.
            ovf_q    <= br ^ br_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed, random (WIDTH=8) and exhaustive (WIDTH=4).
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular arithmetic plus signed range test.
  function automatic void model(input int w, input int a, input int b, input int bin,
                                output int d, output int br, output int ov);
    int sa, sb, r;
    d  = (a - b - bin) & ((1 << w) - 1);
    br = (a < b + bin) ? 1 : 0;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sa - sb - bin;
    ov = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
  endfunction

  task automatic wait_done8(input string tag, input int already);
    int n = already;
    while (bus8.done !== 1'b1 && n < 20) begin
      step();
      n++;
      if (n < 8) chk({tag, "_busy"}, bus8.busy, 1'b1);
    end
    chk({tag, "_latency"}, n, 8);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    int d, br, ov;
    model(8, a, b, bin, d, br, ov);
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
    chk({tag, "_busy0"}, bus8.busy, 1'b1);
    wait_done8(tag, 0);
    chk({tag, "_busyend"}, bus8.busy, 1'b0);
    chk({tag, "_diff"}, bus8.diff, d);
    chk({tag, "_borrow"}, bus8.borrow, br);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, bus8.ovf, ov);
`endif
    step();
    chk({tag, "_donepulse"}, bus8.done, 1'b0);
  endtask

  task automatic run4(input int a, input int b, input int bin);
    int d, br, ov, n;
    model(4, a, b, bin, d, br, ov);
    bus4.a = 4'(a); bus4.b = 4'(b); bus4.bin = 1'(bin); bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    n = 0;
    while (bus4.done !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk($sformatf("x4_%0h_%0h_%0d_lat", a, b, bin), n, 4);
    chk($sformatf("x4_%0h_%0h_%0d_diff", a, b, bin), bus4.diff, d);
    chk($sformatf("x4_%0h_%0h_%0d_borrow", a, b, bin), bus4.borrow, br);
`ifdef SERIAL_SUB_OVF_EN
    chk($sformatf("x4_%0h_%0h_%0d_ovf", a, b, bin), bus4.ovf, ov);
`endif
    step();
    chk($sformatf("x4_%0h_%0h_%0d_once", a, b, bin), bus4.done, 1'b0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", bus8.busy, 1'b0);
    chk("rst_done", bus8.done, 1'b0);
    chk("rst_diff", bus8.diff, 8'h00);
    chk("rst_borrow", bus8.borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", bus8.ovf, 1'b0);
`endif

    run8(8'h05, 8'h03, 1'b0, "t05m03");
    chk("t05m03_const", bus8.diff, 8'h02);
    run8(8'h03, 8'h05, 1'b0, "t03m05");
    chk("t03m05_const", {bus8.borrow, bus8.diff}, 9'h1FE);
    run8(8'h00, 8'h00, 1'b1, "t00m00b");
    chk("t00m00b_const", {bus8.borrow, bus8.diff}, 9'h1FF);

    // Start ignored while busy, then a start accepted in the done cycle.
    bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step();
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    wait_done8("ign", 3);
    chk("ign_diff", bus8.diff, 8'h0F);
    chk("ign_borrow", bus8.borrow, 1'b0);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = 1'b0; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    chk("b2b_busy", bus8.busy, 1'b1);
    chk("b2b_doneoff", bus8.done, 1'b0);
    wait_done8("b2b", 0);
    chk("b2b_diff", bus8.diff, 8'h55);
    chk("b2b_borrow", bus8.borrow, 1'b0);
    step();

    // Abort mid-operation.
    bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.bin = 1'b0; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", bus8.busy, 1'b0);
    chk("abort_done", bus8.done, 1'b0);
    chk("abort_diff", bus8.diff, 8'h00);
    chk("abort_borrow", bus8.borrow, 1'b0);
    seen = 0;
    repeat (12) begin
      step();
      if (bus8.done === 1'b1) seen++;
    end
    chk("abort_nodone", seen, 0);
    run8(8'h37, 8'h12, 1'b0, "post_abort");
    chk("post_abort_const", bus8.diff, 8'h25);

`ifdef SERIAL_SUB_OVF_EN
    run8(8'h80, 8'h01, 1'b0, "ovf80");
    chk("ovf80_const", {bus8.ovf, bus8.borrow, bus8.diff}, 10'h27F);
    run8(8'h7F, 8'hFF, 1'b0, "ovf7f");
    chk("ovf7f_const", {bus8.ovf, bus8.borrow, bus8.diff}, 10'h380);
    run8(8'h05, 8'h03, 1'b0, "ovf05");
    chk("ovf05_const", bus8.ovf, 1'b0);
`endif

    for (int i = 0; i < 40; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(a, b, c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
